// File: rtl/uart_rx_kbd.sv
// 8N1 serial receiver feeding the LC-3 keyboard load port through a one-byte
// holding register, with sticky overrun and framing-error flags.
module uart_rx_kbd #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_Serial,
  input  logic [15:0] KBSR,
  output logic        LD_KBDR_EXT,
  output logic [15:0] KBDR_EXT,
  output logic        LD_KBSR_EXT,
  output logic [15:0] KBSR_EXT,
  output logic        o_Rx_Active,
  output logic        o_Overrun,
  output logic        o_Frame_Err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e        state_q;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          done_q, active_q, frame_q;

  logic [7:0]    hold_q;
  logic          hold_valid_q, ld_q, ovr_q;
  logic [15:0]   kbdr_q, kbsr_q;
  logic          deliver_d, load_d, hold_valid_d;

  // Only the ready bit of KBSR matters here.
  logic          unused_kbsr;
  assign unused_kbsr = ^KBSR[14:0];

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      active_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (!rx_s_q) begin
          state_q  <= START;
          cnt_q    <= '0;
          active_q <= 1'b1;
        end
        START: if (cnt_q == HALF) begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            state_q <= DATA;
            bit_q   <= '0;
          end else begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end else cnt_q <= cnt_q + 1'b1;
        // Counter restarts at mid-start, so each wrap lands on a bit centre.
        DATA: if (cnt_q == LAST) begin
          cnt_q          <= '0;
          shift_q[bit_q] <= rx_s_q;
          if (bit_q == 3'd7) state_q <= STOP;
          else               bit_q   <= bit_q + 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (cnt_q == LAST) begin
          cnt_q    <= '0;
          active_q <= 1'b0;
          if (rx_s_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= WAIT_HIGH;
            frame_q <= 1'b1;
          end
        end else cnt_q <= cnt_q + 1'b1;
        WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  // ld_q blocks the cycle after a strobe, while the datapath's KBSR catches up.
  always_comb begin
    deliver_d    = hold_valid_q & ~KBSR[15] & ~ld_q;
    load_d       = done_q & (~hold_valid_q | deliver_d);
    hold_valid_d = load_d | (hold_valid_q & ~deliver_d);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ld_q         <= 1'b0;
      kbdr_q       <= '0;
      kbsr_q       <= '0;
      ovr_q        <= 1'b0;
    end else begin
      ld_q         <= deliver_d;
      hold_valid_q <= hold_valid_d;
      if (deliver_d) begin
        kbdr_q <= {8'h00, hold_q};
        kbsr_q <= 16'h8000;
      end
      if (load_d)            hold_q <= shift_q;
      if (done_q && !load_d) ovr_q  <= 1'b1;
    end
  end

  assign LD_KBDR_EXT = ld_q;
  assign LD_KBSR_EXT = ld_q;
  assign KBDR_EXT    = kbdr_q;
  assign KBSR_EXT    = kbsr_q;
  assign o_Rx_Active = active_q;
  assign o_Overrun   = ovr_q;
  assign o_Frame_Err = frame_q;

endmodule

// File: tb/tb_uart_rx_kbd.sv
// Directed bench for uart_rx_kbd: byte-level delivery model checked every cycle
// plus literal expectations for each scenario.
module tb_uart_rx_kbd;

  localparam int C = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] KBSR;
  logic        LD_KBDR_EXT, LD_KBSR_EXT;
  logic [15:0] KBDR_EXT, KBSR_EXT;
  logic        o_Rx_Active, o_Overrun, o_Frame_Err;

  logic        kb_hold = 1'b0;
  logic        emu_en = 1'b0;
  logic [15:0] emu_kbsr = 16'h0000;
  int          emu_cnt = 0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] last_kbdr = 16'h0000;
  logic [15:0] last_kbsr = 16'h0000;
  logic [15:0] prev_kb = 16'h0000;
  int          cyc_n = 0;
  int          last_ld = -10;
  int          n_deliv = 0;

  assign KBSR = emu_en ? emu_kbsr : (kb_hold ? 16'h8000 : 16'h0000);

  always #5 clk = ~clk;

  uart_rx_kbd #(.CLKS_PER_BIT(C)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx), .KBSR(KBSR),
    .LD_KBDR_EXT(LD_KBDR_EXT), .KBDR_EXT(KBDR_EXT),
    .LD_KBSR_EXT(LD_KBSR_EXT), .KBSR_EXT(KBSR_EXT),
    .o_Rx_Active(o_Rx_Active), .o_Overrun(o_Overrun), .o_Frame_Err(o_Frame_Err)
  );

  // Per-cycle compare: every strobe must carry the next expected byte, respect
  // the ready bit and minimum spacing; outputs hold otherwise.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (!rst_n) begin
        exp_q.delete();
        last_kbdr = 16'h0000;
        last_kbsr = 16'h0000;
        prev_kb   = 16'h0000;
        emu_kbsr  = 16'h0000;
        emu_cnt   = 0;
        last_ld   = -10;
      end else begin
        checks++;
        if (LD_KBDR_EXT !== LD_KBSR_EXT) begin
          errors++;
          $display("FAIL strobe_pair kbdr_ld=%b kbsr_ld=%b want equal", LD_KBDR_EXT, LD_KBSR_EXT);
        end
        if (LD_KBDR_EXT === 1'b1) begin
          checks++;
          if (prev_kb[15]) begin
            errors++;
            $display("FAIL strobe_while_ready kbsr=%h want bit15=0", prev_kb);
          end
          checks++;
          if (cyc_n - last_ld < 2) begin
            errors++;
            $display("FAIL strobe_gap got=%0d want>=2", cyc_n - last_ld);
          end
          last_ld = cyc_n;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe kbdr=%h want no strobe", KBDR_EXT);
          end else begin
            e = exp_q.pop_front();
            last_kbdr = {8'h00, e};
            last_kbsr = 16'h8000;
            n_deliv++;
          end
        end
        checks++;
        if (KBDR_EXT !== last_kbdr) begin
          errors++;
          $display("FAIL kbdr_ext got=%h want=%h", KBDR_EXT, last_kbdr);
        end
        checks++;
        if (KBSR_EXT !== last_kbsr) begin
          errors++;
          $display("FAIL kbsr_ext got=%h want=%h", KBSR_EXT, last_kbsr);
        end
        // Emulated datapath: strobe sets ready, program reads it 3 cycles later.
        if (emu_en) begin
          if (LD_KBSR_EXT === 1'b1) begin
            emu_kbsr = 16'h8000;
            emu_cnt  = 3;
          end else if (emu_cnt > 0) begin
            emu_cnt--;
            if (emu_cnt == 0) emu_kbsr = 16'h0000;
          end
        end
        prev_kb = emu_en ? emu_kbsr : (kb_hold ? 16'h8000 : 16'h0000);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Leaves the line at the stop level; caller decides what follows.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(C);
    end
    rx = stop;
    cyc(C);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc(1);
    cyc(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d want=0", name, exp_q.size());
    end
  endtask

  initial begin
    int d0;
    logic seen;

    // Reset values
    rst_n = 1'b0;
    rx = 1'b1;
    cyc(3);
    chk("rst_ld_kbdr", {15'd0, LD_KBDR_EXT}, 16'd0);
    chk("rst_ld_kbsr", {15'd0, LD_KBSR_EXT}, 16'd0);
    chk("rst_kbdr", KBDR_EXT, 16'h0000);
    chk("rst_kbsr", KBSR_EXT, 16'h0000);
    chk("rst_active", {15'd0, o_Rx_Active}, 16'd0);
    chk("rst_ovr", {15'd0, o_Overrun}, 16'd0);
    chk("rst_fe", {15'd0, o_Frame_Err}, 16'd0);
    rst_n = 1'b1;
    cyc(5);

    // 1: single byte
    d0 = n_deliv;
    exp_q.push_back(8'h41);
    send_byte(8'h41, 1'b1);
    wait_drain("t1_drain", 40);
    chk("t1_count", 16'(n_deliv - d0), 16'd1);
    chk("t1_kbdr", KBDR_EXT, 16'h0041);
    chk("t1_kbsr", KBSR_EXT, 16'h8000);
    chk("t1_ovr", {15'd0, o_Overrun}, 16'd0);
    chk("t1_fe", {15'd0, o_Frame_Err}, 16'd0);

    // 2: held delivery
    kb_hold = 1'b1;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    cyc(30);
    chk("t2_held", 16'(exp_q.size()), 16'd1);
    kb_hold = 1'b0;
    chk("t2_no_early", {15'd0, LD_KBDR_EXT}, 16'd0);
    cyc(1);
    chk("t2_strobe", {15'd0, LD_KBDR_EXT}, 16'd1);
    chk("t2_kbdr", KBDR_EXT, 16'h005A);
    cyc(4);

    // 3: overrun
    kb_hold = 1'b1;
    d0 = n_deliv;
    exp_q.push_back(8'h31);
    send_byte(8'h31, 1'b1);
    cyc(10);
    chk("t3_ovr_first", {15'd0, o_Overrun}, 16'd0);
    send_byte(8'h32, 1'b1);
    cyc(10);
    chk("t3_ovr", {15'd0, o_Overrun}, 16'd1);
    kb_hold = 1'b0;
    wait_drain("t3_drain", 20);
    cyc(20);
    chk("t3_count", 16'(n_deliv - d0), 16'd1);
    chk("t3_kbdr", KBDR_EXT, 16'h0031);

    // 4: framing error and break
    d0 = n_deliv;
    send_byte(8'hFF, 1'b0);
    cyc(30);
    chk("t4_fe", {15'd0, o_Frame_Err}, 16'd1);
    chk("t4_break_inactive", {15'd0, o_Rx_Active}, 16'd0);
    chk("t4_no_strobe", 16'(n_deliv - d0), 16'd0);
    rx = 1'b1;
    cyc(2 * C);
    exp_q.push_back(8'h0D);
    send_byte(8'h0D, 1'b1);
    wait_drain("t4_drain", 40);
    chk("t4_kbdr", KBDR_EXT, 16'h000D);
    chk("t4_ovr_sticky", {15'd0, o_Overrun}, 16'd1);

    // 5: glitch rejection
    d0 = n_deliv;
    rx = 1'b0;
    cyc(2);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(1);
      if (o_Rx_Active) seen = 1'b1;
    end
    chk("t5_active_seen", {15'd0, seen}, 16'd1);
    for (int i = 0; i < 10 && o_Rx_Active; i++) cyc(1);
    chk("t5_active_drop", {15'd0, o_Rx_Active}, 16'd0);
    cyc(3 * C);
    chk("t5_no_strobe", 16'(n_deliv - d0), 16'd0);
    chk("t5_fe", {15'd0, o_Frame_Err}, 16'd1);
    chk("t5_ovr", {15'd0, o_Overrun}, 16'd1);

    // 6: reset during bit 4 of 8'hAA, then back-to-back bytes
    emu_en = 1'b1;
    rx = 1'b0;
    cyc(C);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 1);
      cyc(C);
    end
    rx = 1'b0;
    cyc(C / 2);
    rst_n = 1'b0;
    cyc(2);
    chk("t6_rst_ld", {15'd0, LD_KBDR_EXT}, 16'd0);
    chk("t6_rst_kbdr", KBDR_EXT, 16'h0000);
    chk("t6_rst_kbsr", KBSR_EXT, 16'h0000);
    chk("t6_rst_active", {15'd0, o_Rx_Active}, 16'd0);
    chk("t6_rst_ovr", {15'd0, o_Overrun}, 16'd0);
    chk("t6_rst_fe", {15'd0, o_Frame_Err}, 16'd0);
    rx = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    d0 = n_deliv;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_drain("t6_drain", 60);
    chk("t6_count", 16'(n_deliv - d0), 16'd2);
    chk("t6_kbdr", KBDR_EXT, 16'h0002);
    chk("t6_ovr", {15'd0, o_Overrun}, 16'd0);
    chk("t6_fe", {15'd0, o_Frame_Err}, 16'd0);
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
